i8008_bus_ctrl: RTL and testbench

//  System-side bus controller for i8008_core. Tracks the core's T-state output and

---
 rtl/i8008_pkg.sv | 32 +++
 rtl/i8008_irq_prio.sv | 44 ++++
 rtl/i8008_bus_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_i8008_bus_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/i8008_pkg.sv
// Shared types for the i8008 system-side bus controller.
package i8008_pkg;

  // Core T-state as presented on the core's state output.
  typedef enum logic [2:0] {
    T1      = 3'd0,
    T1I     = 3'd1,
    T2      = 3'd2,
    WAIT    = 3'd3,
    T3      = 3'd4,
    STOPPED = 3'd5,
    T4      = 3'd6,
    T5      = 3'd7
  } state_t;

  // Cycle type carried in D_out[7:6] during T2.
  typedef enum logic [1:0] {
    PCI = 2'b00,
    PCR = 2'b01,
    PCC = 2'b10,
    PCW = 2'b11
  } cycle_t;

  // Width of the saturating WAIT-edge counter.
  localparam int unsigned WaitCntW = 4;

  // RST v opcode jammed onto the bus during an interrupt fetch.
  function automatic logic [7:0] rst_opcode(input logic [2:0] v);
    return {2'b00, v, 3'b101};
  endfunction

endpackage

// File: rtl/i8008_irq_prio.sv
// Interrupt pending register with rising-edge capture and a fixed-priority
// encoder (line 0 highest). A clear strobe retires the currently selected line.
module i8008_irq_prio #(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic [NUM_IRQ-1:0] i_irq_en,
  input  logic               i_clr,
  output logic               o_valid,
  output logic [2:0]         o_vec
);

  logic [NUM_IRQ-1:0] r_prev;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] w_act;
  logic [NUM_IRQ-1:0] w_clr_mask;

  // Lowest enabled pending index wins; disabled lines stay pending untouched.
  always_comb begin
    w_act   = r_pend & i_irq_en;
    o_valid = |w_act;
    o_vec   = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_act[i]) o_vec = 3'(i);
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_clr_mask[i] = i_clr && o_valid && (o_vec == 3'(i));
    end
  end

  // A new edge on the line being cleared wins, so it stays pending.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= '0;
      r_pend <= '0;
    end else begin
      r_prev <= i_irq;
      r_pend <= (r_pend & ~w_clr_mask) | (i_irq & ~r_prev);
    end
  end

endmodule

// File: rtl/i8008_bus_ctrl.sv
// System-side bus controller for i8008_core: captures the multiplexed address,
// runs memory read/write requests, paces READY and jams RST opcodes on T1I.
module i8008_bus_ctrl
  import i8008_pkg::*;
#(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned WAIT_MIN = 1,
  parameter int unsigned NUM_IRQ  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [2:0]         i_state,
  input  logic [7:0]         i_d_out,
  output logic [7:0]         o_d_in,
  output logic               o_ready,
  output logic               o_intr,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic [NUM_IRQ-1:0] i_irq_en,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic [7:0]         o_mem_wdata,
  input  logic [7:0]         i_mem_rdata,
  input  logic               i_mem_ack,
  output logic [1:0]         o_cyc_type
);

  localparam logic [WaitCntW-1:0] WaitMin = WaitCntW'(WAIT_MIN);

  state_t w_state;
  logic   w_ack;
  logic   w_valid;
  logic [2:0] w_vec;

  logic [ADDR_W-1:0]   r_addr, r_addr_d;
  logic [ADDR_W-1:0]   r_mem_addr, r_mem_addr_d;
  cycle_t              r_cyc, r_cyc_d;
  logic                r_req, r_req_d;
  logic                r_we, r_we_d;
  logic [7:0]          r_wdata, r_wdata_d;
  logic [7:0]          r_d_in, r_d_in_d;
  logic                r_ready, r_ready_d;
  logic                r_have, r_have_d;     // read data held for this cycle
  logic [WaitCntW-1:0] r_cnt, r_cnt_d;
  logic                r_rd_act, r_rd_act_d; // memory read cycle between T2 and T3
  logic                r_rd_defer, r_rd_defer_d;
  logic                r_wr_block, r_wr_block_d;
  logic                r_irq_cyc, r_irq_cyc_d;
  logic [2:0]          r_vec, r_vec_d;

  assign w_state     = state_t'(i_state);
  assign w_ack       = r_req & i_mem_ack;
  assign o_intr      = w_valid;
  assign o_d_in      = r_d_in;
  assign o_ready     = r_ready;
  assign o_mem_req   = r_req;
  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_wdata;
  assign o_cyc_type  = r_cyc;

  i8008_irq_prio #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq_prio (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_irq    (i_irq),
    .i_irq_en (i_irq_en),
    .i_clr    (w_state == T1I),
    .o_valid  (w_valid),
    .o_vec    (w_vec)
  );

  // Next-state for address capture, request handshake, READY and D_in.
  always_comb begin
    r_addr_d     = r_addr;
    r_mem_addr_d = r_mem_addr;
    r_cyc_d      = r_cyc;
    r_req_d      = r_req;
    r_we_d       = r_we;
    r_wdata_d    = r_wdata;
    r_d_in_d     = r_d_in;
    r_ready_d    = r_ready;
    r_have_d     = r_have;
    r_cnt_d      = r_cnt;
    r_rd_act_d   = r_rd_act;
    r_rd_defer_d = r_rd_defer;
    r_wr_block_d = r_wr_block;
    r_irq_cyc_d  = r_irq_cyc;
    r_vec_d      = r_vec;

    if (w_state == T1 || w_state == T1I) begin
      r_addr_d[7:0] = i_d_out;
      r_d_in_d      = 8'h00;
      r_irq_cyc_d   = (w_state == T1I);
      r_rd_act_d    = 1'b0;
      if (w_state == T1I) r_vec_d = w_vec;
    end

    if (w_state == WAIT && r_cnt != '1) r_cnt_d = r_cnt + 1'b1;

    if (w_ack) begin
      r_req_d = 1'b0;
      if (!r_we) begin
        r_d_in_d = i_mem_rdata;
        r_have_d = 1'b1;
      end
      if (r_wr_block) begin
        r_ready_d    = 1'b1;
        r_wr_block_d = 1'b0;
      end
      // A read that queued behind an outstanding write goes out now.
      if (r_rd_defer) begin
        r_req_d      = 1'b1;
        r_we_d       = 1'b0;
        r_mem_addr_d = r_addr;
        r_rd_defer_d = 1'b0;
      end
    end

    if (w_state == T2) begin
      r_addr_d[ADDR_W-1:8] = i_d_out[ADDR_W-9:0];
      r_cyc_d              = cycle_t'(i_d_out[7:6]);
      r_cnt_d              = '0;
      r_have_d             = 1'b0;
      if (r_irq_cyc) begin
        r_d_in_d  = rst_opcode(r_vec);
        r_ready_d = 1'b1;
      end else begin
        case (cycle_t'(i_d_out[7:6]))
          PCC: begin
            r_d_in_d  = 8'h00;
            r_ready_d = 1'b1;
          end
          PCW: begin
            r_ready_d    = !(r_req && !w_ack);
            r_wr_block_d = r_req && !w_ack;
          end
          default: begin
            r_rd_act_d = 1'b1;
            r_ready_d  = 1'b0;
            if (r_req && !w_ack) begin
              r_rd_defer_d = 1'b1;
            end else begin
              r_req_d      = 1'b1;
              r_we_d       = 1'b0;
              r_mem_addr_d = r_addr_d;
            end
          end
        endcase
      end
    end

    if (r_rd_act_d && r_have_d && r_cnt_d >= WaitMin) r_ready_d = 1'b1;

    if (w_state == T3) begin
      r_ready_d  = 1'b0;
      r_rd_act_d = 1'b0;
      // Posted write: the core moves on while the request is outstanding.
      if (r_cyc == PCW && !r_irq_cyc) begin
        r_req_d      = 1'b1;
        r_we_d       = 1'b1;
        r_wdata_d    = i_d_out;
        r_mem_addr_d = r_addr;
      end
    end
  end

  // State registers; reset abandons any request immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr     <= '0;
      r_mem_addr <= '0;
      r_cyc      <= PCI;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_wdata    <= 8'h00;
      r_d_in     <= 8'h00;
      r_ready    <= 1'b0;
      r_have     <= 1'b0;
      r_cnt      <= '0;
      r_rd_act   <= 1'b0;
      r_rd_defer <= 1'b0;
      r_wr_block <= 1'b0;
      r_irq_cyc  <= 1'b0;
      r_vec      <= 3'd0;
    end else begin
      r_addr     <= r_addr_d;
      r_mem_addr <= r_mem_addr_d;
      r_cyc      <= r_cyc_d;
      r_req      <= r_req_d;
      r_we       <= r_we_d;
      r_wdata    <= r_wdata_d;
      r_d_in     <= r_d_in_d;
      r_ready    <= r_ready_d;
      r_have     <= r_have_d;
      r_cnt      <= r_cnt_d;
      r_rd_act   <= r_rd_act_d;
      r_rd_defer <= r_rd_defer_d;
      r_wr_block <= r_wr_block_d;
      r_irq_cyc  <= r_irq_cyc_d;
      r_vec      <= r_vec_d;
    end
  end

endmodule

// File: tb/tb_i8008_bus_ctrl.sv
// Self-checking bench for i8008_bus_ctrl: directed bus cycles with random
// addresses/data/ack latency and a pending-set interrupt model.
module tb_i8008_bus_ctrl;
  import i8008_pkg::*;

  localparam int unsigned ADDR_W   = 14;
  localparam int unsigned WAIT_MIN = 1;
  localparam int unsigned NUM_IRQ  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  state_t      state = T1;
  logic [7:0]  d_out = 8'h00;
  logic [7:0]  d_in;
  logic        ready, intr;
  logic [7:0]  irq = 8'h00;
  logic [7:0]  irq_en = 8'hFF;
  logic        mem_req, mem_we;
  logic [13:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ack = 1'b0;
  logic [1:0]  cyc_type;

  int checks = 0;
  int failures = 0;

  // Interrupt reference model: set of pending lines and last irq levels.
  logic [7:0]  m_pend = 8'h00;
  logic [7:0]  m_prev = 8'h00;
  logic [2:0]  m_vec = 3'd0;
  logic [13:0] last_waddr = '0;

  always #5 clk = ~clk;

  i8008_bus_ctrl #(
    .ADDR_W   (ADDR_W),
    .WAIT_MIN (WAIT_MIN),
    .NUM_IRQ  (NUM_IRQ)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_state     (state),
    .i_d_out     (d_out),
    .o_d_in      (d_in),
    .o_ready     (ready),
    .o_intr      (intr),
    .i_irq       (irq),
    .i_irq_en    (irq_en),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .i_mem_ack   (mem_ack),
    .o_cyc_type  (cyc_type)
  );

  function automatic logic [2:0] lowest(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the interrupt model sees the inputs present at the edge.
  task automatic tick();
    if (rst_n) begin
      if (state == T1I) begin
        m_vec = lowest(m_pend & irq_en);
        if ((m_pend & irq_en) != 8'h00) m_pend[m_vec] = 1'b0;
      end
      m_pend = m_pend | (irq & ~m_prev);
      m_prev = irq;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [7:0] lo, input logic [5:0] hi, input logic [1:0] cyc,
                         input logic [7:0] rdata, input int k);
    state = T1; d_out = lo; tick();
    chk("rd_t1_din", d_in, 0);
    chk("rd_t1_ready", ready, 0);
    state = T2; d_out = {cyc, hi}; tick();
    chk("rd_req", mem_req, 1);
    chk("rd_we", mem_we, 0);
    chk("rd_addr", mem_addr, {hi, lo});
    chk("rd_cyc", cyc_type, cyc);
    chk("rd_t2_ready", ready, 0);
    state = WAIT;
    for (int j = 1; j <= k; j++) begin
      mem_ack   = (j == k);
      mem_rdata = (j == k) ? rdata : 8'($urandom);
      tick();
      chk("rd_ready", ready, (j >= k && j >= int'(WAIT_MIN)));
    end
    mem_ack = 1'b0;
    chk("rd_din", d_in, rdata);
    chk("rd_req_drop", mem_req, 0);
    state = T3; d_out = 8'($urandom); tick();
    chk("rd_t3_ready", ready, 0);
    chk("rd_din_hold", d_in, rdata);
  endtask

  task automatic do_write(input logic [7:0] lo, input logic [5:0] hi, input logic [7:0] wd,
                          input bit blocked, input int k);
    state = T1; d_out = lo; tick();
    if (blocked) chk("wr_addr_hold", mem_addr, last_waddr);
    state = T2; d_out = {2'b11, hi}; tick();
    chk("wr_cyc", cyc_type, 2'b11);
    chk("wr_t2_ready", ready, !blocked);
    if (blocked) begin
      state = WAIT;
      for (int j = 1; j <= k; j++) begin
        mem_ack = (j == k);
        tick();
        chk("wr_blk_ready", ready, (j == k));
      end
      mem_ack = 1'b0;
      chk("wr_blk_req", mem_req, 0);
    end
    state = T3; d_out = wd; tick();
    chk("wr_req", mem_req, 1);
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, {hi, lo});
    chk("wr_wdata", mem_wdata, wd);
    chk("wr_t3_ready", ready, 0);
    last_waddr = {hi, lo};
  endtask

  task automatic do_irq_cycle(input logic [7:0] new_irq);
    state = T1I; d_out = 8'($urandom); irq = irq | new_irq; tick();
    chk("ia_intr", intr, |(m_pend & irq_en));
    state = T2; d_out = 8'h00; tick();
    chk("ia_din", d_in, {2'b00, m_vec, 3'b101});
    chk("ia_ready", ready, 1);
    chk("ia_noreq", mem_req, 0);
    state = T3; tick();
    chk("ia_t3_ready", ready, 0);
  endtask

  initial begin
    // Reset held for three clocks.
    repeat (3) tick();
    chk("rst_din", d_in, 0);
    chk("rst_ready", ready, 0);
    chk("rst_intr", intr, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_cyc", cyc_type, 2'b00);
    rst_n = 1'b1;
    state = T1; d_out = 8'($urandom); tick();
    chk("rel_ready", ready, 0);
    chk("rel_intr", intr, 0);
    chk("rel_req", mem_req, 0);

    // Directed read, then random reads.
    do_read(8'h34, 6'h12, 2'b01, 8'hA5, 2);
    chk("t2_addr", mem_addr, 14'h1234);
    for (int n = 0; n < 4; n++) begin
      do_read(8'($urandom), 6'($urandom), 2'($urandom_range(0, 1)), 8'($urandom),
              int'($urandom_range(1, 4)));
    end

    // Posted write, then a back-to-back write blocked on the first ack.
    do_write(8'($urandom), 6'h01, 8'h77, 1'b0, 0);
    chk("t3_addr_hi", mem_addr[13:8], 6'h01);
    do_write(8'($urandom), 6'($urandom), 8'($urandom), 1'b1, int'($urandom_range(1, 3)));
    mem_ack = 1'b1; state = STOPPED; tick();
    mem_ack = 1'b0;
    chk("wr_final_ack", mem_req, 0);

    // I/O cycle.
    state = T1; d_out = 8'($urandom); tick();
    state = T2; d_out = {2'b10, 6'($urandom)}; tick();
    chk("io_ready", ready, 1);
    chk("io_req", mem_req, 0);
    chk("io_din", d_in, 0);
    chk("io_cyc", cyc_type, 2'b10);
    state = T3; tick();

    // Two pending lines served in priority order.
    irq_en = 8'hFF; irq = 8'b0010_0100; state = STOPPED; tick();
    chk("irq_intr", intr, 1);
    do_irq_cycle(8'h00);
    chk("irq_rst2", d_in, 8'h15);
    do_irq_cycle(8'h00);
    chk("irq_rst5", d_in, 8'h2D);
    chk("irq_drained", intr, 0);

    // Disabled source stays pending until enabled.
    irq = 8'h00; state = STOPPED; tick();
    irq_en = 8'hF7; irq = 8'h08; tick();
    chk("irq_masked", intr, 0);
    irq_en = 8'hFF; tick();
    chk("irq_unmasked", intr, 1);
    do_irq_cycle(8'h00);
    chk("irq_rst3", d_in, 8'h1D);

    // Random interrupt patterns, including edges coincident with T1I.
    for (int n = 0; n < 4; n++) begin
      irq = 8'h00; state = STOPPED; tick();
      irq_en = 8'($urandom); irq = 8'($urandom); tick();
      chk("irq_rand_intr", intr, |(m_pend & irq_en));
      do_irq_cycle(8'($urandom));
      do_irq_cycle(8'h00);
      chk("irq_rand_after", intr, |(m_pend & irq_en));
    end
    irq = 8'h00;

    // Reset while a read is outstanding in WAIT.
    state = T1; d_out = 8'h9A; tick();
    state = T2; d_out = 8'h05; tick();
    state = WAIT; tick();
    chk("pre_rst_req", mem_req, 1);
    rst_n = 1'b0; m_pend = 8'h00; m_prev = 8'h00;
    #1;
    chk("async_req", mem_req, 0);
    chk("async_ready", ready, 0);
    tick();
    tick();
    rst_n = 1'b1;
    do_read(8'h34, 6'h12, 2'b01, 8'hA5, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
